// File: rtl/systolic_sequencer.sv
// Sequencer for a SIZE x SIZE systolic matrix-multiply array: buffers A and B,
// streams skewed row/column wavefronts, waits for PE completion and captures C.
module systolic_sequencer #(
  parameter int SIZE     = 4,
  parameter int I_BITS   = 8,
  parameter int O_BITS   = 2*I_BITS + $clog2(SIZE),
  parameter int WAIT_MAX = 4*SIZE
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_wr_en,
  input  logic                        i_wr_sel,
  input  logic [$clog2(SIZE)-1:0]     i_wr_row,
  input  logic [$clog2(SIZE)-1:0]     i_wr_col,
  input  logic [I_BITS-1:0]           i_wr_data,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_pe_reset,
  output logic [SIZE*I_BITS-1:0]      o_a_full,
  output logic [SIZE*I_BITS-1:0]      o_b_full,
  input  logic [SIZE*SIZE*O_BITS-1:0] i_c_full,
  input  logic [SIZE*SIZE-1:0]        i_finish,
  output logic [SIZE*SIZE*O_BITS-1:0] o_c_full,
  output logic                        o_c_valid
);

  localparam int FW = $clog2(3*SIZE - 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [FW-1:0] FEED_LAST = FW'(3*SIZE - 3);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [FW-1:0]               feed_q, feed_d;
  logic [WW-1:0]               wait_q, wait_d;
  logic [I_BITS-1:0]           a_q [SIZE][SIZE];
  logic [I_BITS-1:0]           a_d [SIZE][SIZE];
  logic [I_BITS-1:0]           b_q [SIZE][SIZE];
  logic [I_BITS-1:0]           b_d [SIZE][SIZE];
  logic [SIZE*I_BITS-1:0]      a_lane_q, a_lane_d;
  logic [SIZE*I_BITS-1:0]      b_lane_q, b_lane_d;
  logic [SIZE*SIZE*O_BITS-1:0] c_q, c_d;
  logic                        c_valid_q, c_valid_d;
  logic                        error_q, error_d;

  always_comb begin
    state_d   = state_q;
    feed_d    = feed_q;
    wait_d    = wait_q;
    a_d       = a_q;
    b_d       = b_q;
    a_lane_d  = '0;
    b_lane_d  = '0;
    c_d       = c_q;
    c_valid_d = c_valid_q;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The write lands at the same edge as a start, so the run sees it.
        if (i_wr_en) begin
          if (i_wr_sel) b_d[i_wr_row][i_wr_col] = i_wr_data;
          else          a_d[i_wr_row][i_wr_col] = i_wr_data;
        end
        if (i_start) begin
          state_d   = S_CLEAR;
          c_valid_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        feed_d  = '0;
      end
      S_FEED: begin
        // Lane k carries element (t-k) of its row/column: the diagonal skew.
        for (int k = 0; k < SIZE; k++) begin
          for (int j = 0; j < SIZE; j++) begin
            if (feed_q == FW'(k + j)) begin
              a_lane_d[k*I_BITS +: I_BITS] = a_q[k][j];
              b_lane_d[k*I_BITS +: I_BITS] = b_q[j][k];
            end
          end
        end
        if (feed_q == FEED_LAST) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end else begin
          feed_d = feed_q + FW'(1);
        end
      end
      S_WAIT: begin
        if (&i_finish) begin
          state_d = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DONE: begin
        c_d       = i_c_full;
        c_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      feed_q    <= '0;
      wait_q    <= '0;
      a_lane_q  <= '0;
      b_lane_q  <= '0;
      c_q       <= '0;
      c_valid_q <= 1'b0;
      error_q   <= 1'b0;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      feed_q    <= feed_d;
      wait_q    <= wait_d;
      a_lane_q  <= a_lane_d;
      b_lane_q  <= b_lane_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      error_q   <= error_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);
  assign o_pe_reset = (state_q == S_CLEAR);
  assign o_error    = error_q;
  assign o_a_full   = a_lane_q;
  assign o_b_full   = b_lane_q;
  assign o_c_full   = c_q;
  assign o_c_valid  = c_valid_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: timeline-based reference model compared every
// cycle, plus directed runs with literal expectations.
module tb_systolic_sequencer;
  localparam int SIZE     = 4;
  localparam int I_BITS   = 8;
  localparam int O_BITS   = 2*I_BITS + $clog2(SIZE);
  localparam int WAIT_MAX = 4*SIZE;
  localparam int IW       = $clog2(SIZE);
  localparam int LW       = SIZE*I_BITS;
  localparam int CW       = SIZE*SIZE*O_BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 i_reset, i_wr_en, i_wr_sel, i_start;
  logic [IW-1:0]        i_wr_row, i_wr_col;
  logic [I_BITS-1:0]    i_wr_data;
  logic                 o_busy, o_done, o_error, o_pe_reset, o_c_valid;
  logic [LW-1:0]        o_a_full, o_b_full;
  logic [CW-1:0]        i_c_full, o_c_full;
  logic [SIZE*SIZE-1:0] i_finish;

  systolic_sequencer #(.SIZE(SIZE), .I_BITS(I_BITS), .O_BITS(O_BITS), .WAIT_MAX(WAIT_MAX)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
    .i_wr_row(i_wr_row), .i_wr_col(i_wr_col), .i_wr_data(i_wr_data), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_pe_reset(o_pe_reset),
    .o_a_full(o_a_full), .o_b_full(o_b_full), .i_c_full(i_c_full), .i_finish(i_finish),
    .o_c_full(o_c_full), .o_c_valid(o_c_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: operand matrices, captured result, and position in a run
  // counted in cycles since the start edge (rel 1 = array-reset cycle).
  logic [I_BITS-1:0] am [SIZE][SIZE];
  logic [I_BITS-1:0] bm [SIZE][SIZE];
  logic [CW-1:0]     cm;
  bit                cvm, errm, in_run, model_ok;
  int                rel, done_rel;

  initial begin
    model_ok = 0; in_run = 0; rel = 0; done_rel = -1; errm = 0; cvm = 0; cm = '0;
    forever begin
      @(posedge clk);
      errm = 0;
      if (i_reset) begin
        for (int r = 0; r < SIZE; r++)
          for (int c = 0; c < SIZE; c++) begin
            am[r][c] = '0;
            bm[r][c] = '0;
          end
        cm = '0; cvm = 0; in_run = 0; model_ok = 1;
      end else if (!in_run) begin
        if (i_wr_en) begin
          if (i_wr_sel) bm[i_wr_row][i_wr_col] = i_wr_data;
          else          am[i_wr_row][i_wr_col] = i_wr_data;
        end
        if (i_start) begin
          in_run = 1; rel = 1; done_rel = -1; cvm = 0;
        end
      end else begin
        // Waiting begins after 1 reset cycle and 3*SIZE-2 feed cycles.
        if (rel == done_rel) begin
          cm = i_c_full; cvm = 1; in_run = 0;
        end else if (rel >= 3*SIZE) begin
          if (&i_finish) done_rel = rel + 1;
          else if (rel - 3*SIZE == WAIT_MAX - 1) begin
            in_run = 0; errm = 1;
          end
        end
        rel++;
      end
    end
  end

  // Data for feed step t is visible at rel t+3; lane k shows element t-k.
  function automatic logic [LW-1:0] exp_lanes(input bit is_b);
    logic [LW-1:0] v;
    int t, j;
    v = '0;
    if (in_run && rel >= 3) begin
      t = rel - 3;
      for (int k = 0; k < SIZE; k++) begin
        j = t - k;
        if (j >= 0 && j < SIZE) v[k*I_BITS +: I_BITS] = is_b ? bm[j][k] : am[k][j];
      end
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] matmul();
    logic [CW-1:0] v;
    int s;
    v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        s = 0;
        for (int k = 0; k < SIZE; k++) s += int'(am[r][k]) * int'(bm[k][c]);
        v[(r*SIZE+c)*O_BITS +: O_BITS] = O_BITS'(s);
      end
    return v;
  endfunction

  function automatic logic [O_BITS-1:0] elem(input logic [CW-1:0] v, input int r, input int c);
    return v[(r*SIZE+c)*O_BITS +: O_BITS];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("busy",     CW'(o_busy),     CW'(in_run));
        check("done",     CW'(o_done),     CW'(in_run && rel == done_rel));
        check("error",    CW'(o_error),    CW'(errm));
        check("pe_reset", CW'(o_pe_reset), CW'(in_run && rel == 1));
        check("a_lanes",  CW'(o_a_full),   CW'(exp_lanes(1'b0)));
        check("b_lanes",  CW'(o_b_full),   CW'(exp_lanes(1'b1)));
        check("c_full",   o_c_full,        cm);
        check("c_valid",  CW'(o_c_valid),  CW'(cvm));
        if (o_done) done_cnt++;
      end
    end
  end

  int rel_tb = 0;

  task automatic step();
    @(posedge clk);
    #1;
    rel_tb++;
  endtask

  task automatic go_to(input int r);
    while (rel_tb < r) step();
  endtask

  task automatic wr(input bit sel, input int r, input int c, input int d);
    i_wr_en = 1; i_wr_sel = sel; i_wr_row = IW'(r); i_wr_col = IW'(c); i_wr_data = I_BITS'(d);
    step();
    i_wr_en = 0;
  endtask

  task automatic start_run();
    i_start = 1;
    step();
    i_start = 0;
    rel_tb = 1;
  endtask

  // Stub array: raise all finish flags during cycle r with the product on i_c_full.
  task automatic finish_at(input int r);
    go_to(r);
    i_c_full = matmul();
    i_finish = '1;
    step();
    i_finish = '0;
  endtask

  int dc, seen;

  initial begin
    i_reset = 1; i_wr_en = 0; i_wr_sel = 0; i_wr_row = '0; i_wr_col = '0; i_wr_data = '0;
    i_start = 0; i_c_full = '0; i_finish = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy",   CW'(o_busy),    '0);
    check("rst_cvalid", CW'(o_c_valid), '0);
    check("rst_lanes",  CW'(o_a_full),  '0);
    i_reset = 0;
    step();

    // Identity times B: C equals B.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        wr(1'b0, r, c, (r == c) ? 1 : 0);
        wr(1'b1, r, c, r*4 + c);
      end
    start_run();
    finish_at(14);
    @(negedge clk);
    check("t1_done_pulse", CW'(o_done), CW'(1));
    step();
    @(negedge clk);
    check("t1_cvalid", CW'(o_c_valid), CW'(1));
    check("t1_busy",   CW'(o_busy),    '0);
    check("t1_c23",    CW'(elem(o_c_full, 2, 3)), CW'(11));
    check("t1_c01",    CW'(elem(o_c_full, 0, 1)), CW'(1));

    // Lane skew with A[k][j] = 16k+j.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) wr(1'b0, r, c, 16*r + c);
    start_run();
    go_to(3);
    @(negedge clk);
    check("t2_a_t0_upper", CW'(o_a_full[LW-1:I_BITS]), '0);
    check("t2_b_t0",       CW'(o_b_full), '0);
    go_to(6);
    @(negedge clk);
    check("t2_a_t3", CW'(o_a_full), CW'(32'h3021_1203));
    check("t2_b_t3", CW'(o_b_full), CW'(32'h0306_090C));
    finish_at(13);
    step();

    // Full-scale operands.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        wr(1'b0, r, c, 255);
        wr(1'b1, r, c, 255);
      end
    start_run();
    finish_at(14);
    step();
    @(negedge clk);
    check("t3_c00", CW'(elem(o_c_full, 0, 0)), CW'(260100));
    check("t3_c33", CW'(elem(o_c_full, 3, 3)), CW'(260100));

    // Timeout with finish held low and garbage on i_c_full.
    i_c_full = '1;
    dc = done_cnt;
    seen = 0;
    start_run();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (o_error) begin
        seen = rel_tb;
        break;
      end
      step();
    end
    check("t4_error_cycle", CW'(seen), CW'(28));
    check("t4_no_done",     CW'(done_cnt - dc), '0);
    check("t4_c_kept",      CW'(elem(o_c_full, 1, 2)), CW'(260100));
    step();

    // Start and write requests mid-feed are ignored.
    dc = done_cnt;
    start_run();
    go_to(4);
    i_start = 1; i_wr_en = 1; i_wr_sel = 0; i_wr_row = '0; i_wr_col = '0; i_wr_data = 8'd99;
    step();
    i_start = 0; i_wr_en = 0;
    finish_at(13);
    repeat (3) step();
    @(negedge clk);
    check("t5_one_done", CW'(done_cnt - dc), CW'(1));
    check("t5_idle",     CW'(o_busy), '0);
    check("t5_c00",      CW'(elem(o_c_full, 0, 0)), CW'(260100));

    // Reset mid-feed clears everything; the next run yields zeros.
    start_run();
    go_to(4);
    i_reset = 1;
    step();
    i_reset = 0;
    @(negedge clk);
    check("t6_busy",   CW'(o_busy),    '0);
    check("t6_c_full", o_c_full,       '0);
    check("t6_error",  CW'(o_error),   '0);
    start_run();
    go_to(6);
    @(negedge clk);
    check("t6_a_zero", CW'(o_a_full), '0);
    finish_at(14);
    step();
    @(negedge clk);
    check("t6_cvalid", CW'(o_c_valid), CW'(1));
    check("t6_c_zero", o_c_full, '0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
Sequencer for the SIZE x SIZE systolic matrix-multiply array. It holds operand matrices A and B in local register buffers loaded by an element-write port. On start it pulses the array reset and streams A rows and B columns as skewed wavefronts. It then waits for all PE finish flags, captures the product matrix C and reports done, or reports an error on timeout. It sits between the host/register-file side and the array instance.

Parameters:
SIZE, 4, matrix dimension (array is SIZE x SIZE)
I_BITS, 8, operand element width (unsigned)
O_BITS, 2*I_BITS+$clog2(SIZE), result element width
WAIT_MAX, 4*SIZE, maximum WAIT-state cycles before timeout

Ports:
i_clock  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_wr_en  in  1  operand element write strobe
i_wr_sel  in  1  0 = write A buffer, 1 = write B buffer
i_wr_row  in  $clog2(SIZE)  element row index
i_wr_col  in  $clog2(SIZE)  element column index
i_wr_data  in  I_BITS  element value
i_start  in  1  start-multiply request, sampled in IDLE only
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse: C captured successfully
o_error  out  1  one-cycle pulse: finish timeout
o_pe_reset  out  1  reset to the array a/b reset chain
o_a_full  out  SIZE*I_BITS  A lanes to the array; lane k is bits [k*I_BITS +: I_BITS]
o_b_full  out  SIZE*I_BITS  B lanes to the array, same packing
i_c_full  in  SIZE*SIZE*O_BITS  array results; C[r][c] at index r*SIZE+c
i_finish  in  SIZE*SIZE  per-PE finish flags
o_c_full  out  SIZE*SIZE*O_BITS  latched product matrix, same packing as i_c_full
o_c_valid  out  1  high from DONE until the next start or reset

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - state returns to IDLE, and the A/B buffers, o_c_full and the feed/wait counters clear to 0
  - o_busy, o_done, o_error, o_c_valid and o_pe_reset are 0
  - o_a_full and o_b_full are 0
  - reset overrides every other input in the same cycle, including mid-operation
- Write port:
  - while i_wr_en=1 in IDLE, the buffer selected by i_wr_sel takes element [i_wr_row][i_wr_col] = i_wr_data at the next edge
  - writes are ignored while o_busy=1
  - a write and a start in the same IDLE cycle: the write lands first, so the run uses the new value
- States and transitions:
  - IDLE: o_a_full/o_b_full = 0. i_start=1 -> CLEAR, and o_c_valid drops to 0.
  - CLEAR: exactly 1 cycle with o_pe_reset=1 and lanes 0 -> FEED.
  - FEED: a feed counter t runs 0..3*SIZE-3 (3*SIZE-2 cycles).
    - lane k of o_a_full = A[k][t-k] when 0 <= t-k < SIZE, else 0
    - lane k of o_b_full = B[t-k][k] under the same condition, else 0
    - lanes are registered outputs, so lane data for t appears the cycle after the t-th FEED edge
    - after the last t -> WAIT
  - WAIT: lanes 0 and a wait counter increments each cycle.
    - &i_finish = 1 -> DONE
    - otherwise, when the counter reaches WAIT_MAX-1 -> IDLE, with o_error pulsed for 1 cycle and o_c_full/o_c_valid unchanged
    - if finish and timeout occur in the same cycle, finish wins
  - DONE: 1 cycle. o_c_full <= i_c_full, o_c_valid <= 1, o_done = 1 -> IDLE.
- i_start is ignored outside IDLE; there is no queueing.
- Latency: start to o_done = 1 (CLEAR) + 3*SIZE-2 (FEED) + wait cycles + 1, with o_done asserted in the DONE cycle.
- Arithmetic: the sequencer performs no arithmetic on data. Buffers and the result capture are width-exact, with no truncation; O_BITS covers SIZE products of maximum value.
- Counters are sized with $clog2 to hold 3*SIZE-2 and WAIT_MAX without wrap.

Test Plan:
- Load A = identity and B[r][c] = r*4+c (values 0..15), start, finish stub asserts all flags 2 cycles into WAIT -> o_done pulses once, o_c_full equals the stub's i_c_full, o_c_valid=1, o_busy low the next cycle.
- Lane skew check, SIZE=4, A[k][j] = 16*k+j: in FEED t=3, lanes 0..3 carry A[0][3]=3, A[1][2]=18, A[2][1]=33, A[3][0]=48; at t=0, lanes 1..3 are 0.
- All operands 255 with a real array instance -> every C element = 260100 (4*255*255), fits in O_BITS=18.
- Hold i_finish at 0 throughout WAIT -> o_error pulses exactly WAIT_MAX cycles after WAIT entry, o_done never pulses, o_c_full keeps the prior result.
- Pulse i_start and i_wr_en (A[0][0]=99) during FEED -> run unaffected, A[0][0] keeps its old value, no second run starts.
- Assert i_reset at FEED t=2 -> next cycle IDLE, all outputs and buffers 0. A following start with zero buffers yields a C of all zeros.
